// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial feeder for the MSB-first serial comparator: one load/clear cycle, then WIDTH
// bit cycles. Optional result capture is enabled with SERIAL_RESULT_CAPTURE_EN.
module serial_operand_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last,
`ifdef SERIAL_RESULT_CAPTURE_EN
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             res_valid,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt,
`endif
    output logic             cmp_rst
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntTop = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sr_d  = a_word;
                    b_sr_d  = b_word;
                    cnt_d   = CntTop;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Shift by operator so WIDTH == 1 needs no special case.
                a_sr_d = a_sr_q << 1;
                b_sr_d = b_sr_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only; in_valid never reaches them combinationally.
    always_comb begin
        in_ready  = 1'b1;
        cmp_rst   = 1'b1;
        ser_valid = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        if (state_q == StShift) begin
            in_ready  = 1'b0;
            cmp_rst   = 1'b0;
            ser_valid = 1'b1;
            ser_a     = a_sr_q[WIDTH-1];
            ser_b     = b_sr_q[WIDTH-1];
            ser_first = (cnt_q == CntTop);
            ser_last  = (cnt_q == '0);
        end
    end

`ifdef SERIAL_RESULT_CAPTURE_EN
    logic res_valid_q, res_lt_q, res_eq_q, res_gt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_lt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_gt_q    <= 1'b0;
        end else begin
            res_valid_q <= ser_last;
            if (ser_last) begin
                res_lt_q <= cmp_lt;
                res_eq_q <= cmp_eq;
                res_gt_q <= cmp_gt;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_lt    = res_lt_q;
    assign res_eq    = res_eq_q;
    assign res_gt    = res_gt_q;
`endif

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench: WIDTH=4 instance for framing, throughput and reset, WIDTH=1 instance for the
// single-bit corner. Capture checks compile in when SERIAL_RESULT_CAPTURE_EN is defined.
module tb_serial_operand_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] a_word, b_word;
    logic       ser_valid, ser_a, ser_b, ser_first, ser_last, cmp_rst;

    logic       in_valid_w1, in_ready_w1;
    logic [0:0] a_word_w1, b_word_w1;
    logic       ser_valid_w1, ser_a_w1, ser_b_w1, ser_first_w1, ser_last_w1, cmp_rst_w1;

`ifdef SERIAL_RESULT_CAPTURE_EN
    logic cmp_lt, cmp_eq, cmp_gt;
    logic res_valid, res_lt, res_eq, res_gt;
    logic res_valid_w1, res_lt_w1, res_eq_w1, res_gt_w1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_operand_serializer #(.WIDTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .ser_valid (ser_valid),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_first (ser_first),
        .ser_last  (ser_last),
`ifdef SERIAL_RESULT_CAPTURE_EN
        .cmp_lt    (cmp_lt),
        .cmp_eq    (cmp_eq),
        .cmp_gt    (cmp_gt),
        .res_valid (res_valid),
        .res_lt    (res_lt),
        .res_eq    (res_eq),
        .res_gt    (res_gt),
`endif
        .cmp_rst   (cmp_rst)
    );

    serial_operand_serializer #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_w1),
        .in_ready  (in_ready_w1),
        .a_word    (a_word_w1),
        .b_word    (b_word_w1),
        .ser_valid (ser_valid_w1),
        .ser_a     (ser_a_w1),
        .ser_b     (ser_b_w1),
        .ser_first (ser_first_w1),
        .ser_last  (ser_last_w1),
`ifdef SERIAL_RESULT_CAPTURE_EN
        .cmp_lt    (1'b0),
        .cmp_eq    (1'b0),
        .cmp_gt    (1'b0),
        .res_valid (res_valid_w1),
        .res_lt    (res_lt_w1),
        .res_eq    (res_eq_w1),
        .res_gt    (res_gt_w1),
`endif
        .cmp_rst   (cmp_rst_w1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Back-to-back word table: A, B and expected {lt, eq, gt}.
    logic [3:0] tab_a [3] = '{4'd9, 4'd5, 4'd7};
    logic [3:0] tab_b [3] = '{4'd5, 4'd9, 4'd7};
    logic [2:0] tab_r [3] = '{3'b001, 3'b100, 3'b010};

    initial begin
        logic [3:0] exp_a, exp_b, got_a, got_b;
        int         acc [3];
        logic       crst [20];
        logic       sval [20];
        int         n_acc, cnt_crst, cnt_sval, n_rv;
        logic       upd, pending;

        rst = 1'b0; in_valid = 1'b0; a_word = '0; b_word = '0;
        in_valid_w1 = 1'b0; a_word_w1 = '0; b_word_w1 = '0;
`ifdef SERIAL_RESULT_CAPTURE_EN
        cmp_lt = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0;
`endif

        // Reset held three cycles
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_cmp_rst", cmp_rst, 1);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_framing", {ser_first, ser_last}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_ser_valid", ser_valid, 0);

        // Bit order and framing: A=1010, B=0110
        exp_a = 4'b1010; exp_b = 4'b0110;
        a_word = exp_a; b_word = exp_b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a_word = 4'hC; b_word = 4'h3;
        for (int i = 0; i < 4; i++) begin
            check("frm_ser_a", ser_a, exp_a[3-i]);
            check("frm_ser_b", ser_b, exp_b[3-i]);
            check("frm_first", ser_first, (i == 0));
            check("frm_last", ser_last, (i == 3));
            check("frm_ready_cmp_rst", {in_ready, cmp_rst, ser_valid}, 3'b001);
            @(negedge clk);
        end
        check("frm_idle", {in_ready, cmp_rst, ser_valid}, 3'b110);

        // Back-to-back throughput with sustained in_valid
        a_word = tab_a[0]; b_word = tab_b[0]; in_valid = 1'b1;
        n_acc = 0; upd = 1'b0; pending = 1'b0; n_rv = 0;
        got_a = '0; got_b = '0;
        for (int i = 0; i < 3; i++) acc[i] = -100;
        for (int c = 0; c < 20; c++) begin
            crst[c] = cmp_rst;
            sval[c] = ser_valid;
`ifdef SERIAL_RESULT_CAPTURE_EN
            n_rv += int'(res_valid);
            if (pending) begin
                check("cap_res_valid", res_valid, 1);
                check("cap_result", {res_lt, res_eq, res_gt}, tab_r[n_acc-1 < 0 ? 0 :
                      (ser_valid ? n_acc - 2 : n_acc - 1)]);
                pending = 1'b0;
            end
            cmp_lt = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0;
`endif
            if (upd) begin
                upd = 1'b0;
                if (n_acc < 3) begin
                    a_word = tab_a[n_acc]; b_word = tab_b[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ser_valid) begin
                got_a = {got_a[2:0], ser_a};
                got_b = {got_b[2:0], ser_b};
            end
            if (ser_last && n_acc > 0) begin
                check("b2b_word_a", got_a, tab_a[n_acc-1]);
                check("b2b_word_b", got_b, tab_b[n_acc-1]);
`ifdef SERIAL_RESULT_CAPTURE_EN
                {cmp_lt, cmp_eq, cmp_gt} = tab_r[n_acc-1];
                pending = 1'b1;
`endif
            end
            if (in_ready && in_valid && n_acc < 3) begin
                acc[n_acc] = c;
                n_acc++;
                upd = 1'b1;
            end
            @(negedge clk);
        end
        check("b2b_accepts", n_acc, 3);
        check("b2b_gap01", acc[1] - acc[0], 5);
        check("b2b_gap12", acc[2] - acc[1], 5);
        cnt_crst = 0; cnt_sval = 0;
        for (int c = 1; c < 20; c++) begin
            if (c > acc[0] && c <= acc[1]) begin
                cnt_crst += int'(crst[c]);
                cnt_sval += int'(sval[c]);
            end
        end
        check("b2b_cmp_rst_gap", cnt_crst, 1);
        check("b2b_bit_cycles", cnt_sval, 4);
`ifdef SERIAL_RESULT_CAPTURE_EN
        check("cap_pulses", n_rv, 3);
        check("cap_hold", {res_valid, res_lt, res_eq, res_gt}, 4'b0010);
`endif

        // Reset during a word: A=F abandoned after two bits
        a_word = 4'hF; b_word = 4'h0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_bit1", {ser_valid, ser_a, ser_first}, 3'b111);
        @(negedge clk);
        check("mid_bit2", {ser_valid, ser_a, ser_first}, 3'b110);
        rst = 1'b0;
        #1;
        check("mid_rst_async", {in_ready, cmp_rst, ser_valid, ser_a, ser_b, ser_first, ser_last},
              7'b1100000);
`ifdef SERIAL_RESULT_CAPTURE_EN
        check("mid_rst_res", {res_valid, res_lt, res_eq, res_gt}, 4'b0000);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_after_release", {in_ready, ser_valid}, 2'b10);
        exp_a = 4'h3; exp_b = 4'h3;
        a_word = exp_a; b_word = exp_b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mid_next_ab", {ser_a, ser_b}, {exp_a[3-i], exp_b[3-i]});
            check("mid_next_frame", {ser_valid, ser_first, ser_last}, {1'b1, i == 0, i == 3});
`ifdef SERIAL_RESULT_CAPTURE_EN
            check("mid_no_res_valid", res_valid, 0);
`endif
            @(negedge clk);
        end

        // WIDTH=1 corner: first and last coincide
        a_word_w1 = 1'b1; b_word_w1 = 1'b0; in_valid_w1 = 1'b1;
        @(negedge clk);
        in_valid_w1 = 1'b0;
        check("w1_shift", {ser_valid_w1, ser_first_w1, ser_last_w1, ser_a_w1, ser_b_w1},
              5'b11110);
        check("w1_busy", {in_ready_w1, cmp_rst_w1}, 2'b00);
        @(negedge clk);
        check("w1_idle", {in_ready_w1, cmp_rst_w1, ser_valid_w1}, 3'b110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
- Upstream feeder for the MSB-first serial comparator.
- Accepts two parallel operands through a valid/ready handshake and shifts them out one bit pair per clock, most significant bit first.
- Generates the comparator's synchronous clear (`cmp_rst`) and word framing (`ser_first`, `ser_last`), so the comparator starts every word from the "equal" state.
- One word takes WIDTH+1 cycles: one load/clear cycle plus WIDTH bit cycles.

Parameters:
- `WIDTH`, default 8: operand width in bits; legal range ≥ 1.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clk` (synchroniser is external).
- `in_valid`  input  1  operand pair present on `a_word`/`b_word`.
- `in_ready`  output  1  block can accept an operand pair this cycle.
- `a_word`  input  WIDTH  operand A, parallel.
- `b_word`  input  WIDTH  operand B, parallel.
- `ser_valid`  output  1  `ser_a`/`ser_b` carry a live bit this cycle.
- `ser_a`  output  1  current bit of A, MSB first; drives comparator input `a`.
- `ser_b`  output  1  current bit of B, MSB first; drives comparator input `b`.
- `ser_first`  output  1  high on the MSB cycle.
- `ser_last`  output  1  high on the LSB cycle; the comparator result is valid in this cycle.
- `cmp_rst`  output  1  active-high synchronous clear to the comparator's `rst`.

Behaviour:
- States: IDLE and SHIFT. Stored state:
  - a shift register per operand (WIDTH bits);
  - a bit counter, `$clog2(WIDTH+1)` bits wide.
- While `rst` is low, asynchronously:
  - state = IDLE, shift registers = 0, counter = 0;
  - `in_ready` = 1, `ser_valid` = `ser_a` = `ser_b` = `ser_first` = `ser_last` = 0, `cmp_rst` = 1.
- IDLE:
  - Outputs: `in_ready` = 1, `cmp_rst` = 1, `ser_valid` = 0, `ser_a` = `ser_b` = 0.
  - On posedge with `in_valid` = 1: load `a_word`/`b_word` into the shift registers, set counter = WIDTH-1, go to SHIFT.
  - With `in_valid` = 0: stay in IDLE; operand inputs are ignored.
- SHIFT:
  - Outputs: `in_ready` = 0, `cmp_rst` = 0, `ser_valid` = 1.
  - `ser_a`/`ser_b` = MSB of the respective shift register.
  - `ser_first` = 1 when counter == WIDTH-1; `ser_last` = 1 when counter == 0.
  - Each posedge: shift both registers left by one, fill the LSB with 0, decrement the counter.
  - On posedge with counter == 0: go to IDLE. `in_valid` is ignored throughout SHIFT.
- Timing: handshake accepted at edge N.
  - Bits appear in cycles N+1 … N+WIDTH.
  - `ser_last` is high in cycle N+WIDTH.
  - Cycle N+WIDTH+1 is IDLE with `cmp_rst` = 1; a new word may be accepted at that edge.
- Sustained `in_valid` gives exactly one word every WIDTH+1 cycles. Back-to-back words never share a cycle.
- WIDTH = 1: `ser_first` and `ser_last` are both high in the single SHIFT cycle.
- Reset asserted mid-word: the word is abandoned immediately, with no partial result. After release the block is in IDLE.
- All outputs are driven combinationally from registered state only; there is no combinational path from `in_valid` to any output.

Optional Feature:
- Macro: `SERIAL_RESULT_CAPTURE_EN`.
- With the macro defined, the block adds:
  - inputs `cmp_lt`, `cmp_eq`, `cmp_gt` (1 bit each, from the comparator outputs);
  - outputs `res_valid`, `res_lt`, `res_eq`, `res_gt` (1 bit each, registered).
- Capture rule: on the posedge where `ser_last` = 1, `res_lt`/`res_eq`/`res_gt` are loaded from `cmp_*` and `res_valid` pulses high for exactly the following cycle.
- Result hold:
  - `res_lt`/`res_eq`/`res_gt` hold their value until the next capture.
  - Reset clears all four outputs to 0.
  - A reset mid-word produces no `res_valid`.
- Without the macro: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset state: hold `rst` low 3 cycles → `in_ready` = 1, `cmp_rst` = 1, `ser_valid` = 0; release → still IDLE.
- Bit order and framing: WIDTH=4, accept A=4'b1010, B=4'b0110 → `ser_a` = 1,0,1,0 and `ser_b` = 0,1,1,0 on consecutive cycles; `ser_first` on cycle 1, `ser_last` on cycle 4; `in_ready` = 0 for those 4 cycles.
- Back-to-back throughput: `in_valid` held high with 3 words → acceptances exactly 5 cycles apart; `cmp_rst` = 1 for one cycle between words.
- Reset mid-word: reset after bit 2 of A=4'hF → outputs return to reset values at once; the next word (A=4'h3, B=4'h3) serialises correctly from its MSB.
- WIDTH=1: A=1, B=0 → one SHIFT cycle with `ser_first` = `ser_last` = 1 and `ser_a` = 1, `ser_b` = 0.
- Capture with comparator attached (`SERIAL_RESULT_CAPTURE_EN`): pairs (9,5), (5,9), (7,7) → captured results gt, lt, eq respectively; one `res_valid` pulse per word.
